// File: rtl/int_sequencer.sv
// Interrupt entry/exit sequencer: synchronizes three IRQ lines, arbitrates by fixed
// priority with nesting, and issues one flush/redirect pulse in a safe EX slot.
module int_sequencer #(
  parameter int unsigned      WIDTH    = 32,
  parameter logic [WIDTH-1:0] VEC_BASE = 32'h0000_1000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       irq_in,
  input  logic             ie,
  input  logic             ex_valid,
  input  logic [WIDTH-1:0] ex_pc,
  input  logic             ex_redirect,
  input  logic             stall,
  input  logic             uret_ex,
  output logic             int_take,
  output logic [WIDTH-1:0] int_target,
  output logic             epc_we,
  output logic [WIDTH-1:0] epc_out,
  output logic [1:0]       cause_out,
  output logic             ie_clear,
  output logic [2:0]       pending,
  output logic [2:0]       in_service,
  output logic [1:0]       state_dbg
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    COOL = 2'd2
  } state_t;

  state_t     state_q;
  logic [1:0] cnt_q;
  logic [2:0] sync1_q, sync2_q, prev_q;
  logic [2:0] pending_q, in_service_q;

  logic [2:0] rise;
  logic [2:0] allowed;
  logic [2:0] eligible;
  logic       any_eligible;
  logic [1:0] sel;
  logic [2:0] sel_mask;
  logic [2:0] uret_mask;
  logic       slot_ok;

  assign rise = sync2_q & ~prev_q;

  // Only sources strictly above the current in-service level may nest.
  always_comb begin
    allowed = 3'b111;
    if (in_service_q[2])      allowed = 3'b000;
    else if (in_service_q[1]) allowed = 3'b100;
    else if (in_service_q[0]) allowed = 3'b110;
  end

  assign eligible     = pending_q & {3{ie}} & allowed;
  assign any_eligible = |eligible;

  always_comb begin
    sel = 2'd0;
    if (eligible[2])      sel = 2'd2;
    else if (eligible[1]) sel = 2'd1;
  end

  assign sel_mask = 3'b001 << sel;

  always_comb begin
    uret_mask = 3'b000;
    if (in_service_q[2])      uret_mask = 3'b100;
    else if (in_service_q[1]) uret_mask = 3'b010;
    else if (in_service_q[0]) uret_mask = 3'b001;
  end

  assign slot_ok  = ex_valid & ~stall & ~ex_redirect & ~uret_ex;
  assign int_take = (state_q == ARM) & any_eligible & slot_ok;

  assign int_target = int_take ? (VEC_BASE + (WIDTH'(sel) << 4)) : '0;
  assign epc_we     = int_take;
  assign ie_clear   = int_take;
  assign epc_out    = int_take ? ex_pc : '0;
  assign cause_out  = int_take ? sel : 2'd0;
  assign pending    = pending_q;
  assign in_service = in_service_q;
  assign state_dbg  = state_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
      prev_q  <= '0;
    end else begin
      sync1_q <= irq_in;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  // A fresh edge in the same cycle as a take re-sets the bit, so the set wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending_q    <= '0;
      in_service_q <= '0;
    end else begin
      pending_q <= (pending_q & ~(int_take ? sel_mask : 3'b000)) | rise;
      if (int_take)     in_service_q <= in_service_q | sel_mask;
      else if (uret_ex) in_service_q <= in_service_q & ~uret_mask;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE: if (any_eligible) state_q <= ARM;
        ARM: begin
          if (!any_eligible) begin
            state_q <= IDLE;
          end else if (slot_ok) begin
            state_q <= COOL;
            cnt_q   <= '0;
          end
        end
        COOL: begin
          cnt_q <= cnt_q + 2'd1;
          if (cnt_q == 2'd1) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_int_sequencer.sv
// Directed bench for int_sequencer: hand-computed vectors checked with immediate
// assertions, one linear initial block.
module tb_int_sequencer;

  localparam int WIDTH = 32;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ARM  = 2'd1;

  logic             clk;
  logic             rst;
  logic [2:0]       irq_in;
  logic             ie;
  logic             ex_valid;
  logic [WIDTH-1:0] ex_pc;
  logic             ex_redirect;
  logic             stall;
  logic             uret_ex;
  logic             int_take;
  logic [WIDTH-1:0] int_target;
  logic             epc_we;
  logic [WIDTH-1:0] epc_out;
  logic [1:0]       cause_out;
  logic             ie_clear;
  logic [2:0]       pending;
  logic [2:0]       in_service;
  logic [1:0]       state_dbg;

  int checks;
  int errors;

  int_sequencer #(.WIDTH(WIDTH), .VEC_BASE(32'h0000_1000)) dut (
    .clk(clk), .rst(rst), .irq_in(irq_in), .ie(ie), .ex_valid(ex_valid),
    .ex_pc(ex_pc), .ex_redirect(ex_redirect), .stall(stall), .uret_ex(uret_ex),
    .int_take(int_take), .int_target(int_target), .epc_we(epc_we),
    .epc_out(epc_out), .cause_out(cause_out), .ie_clear(ie_clear),
    .pending(pending), .in_service(in_service), .state_dbg(state_dbg)
  );

  // clock/reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; irq_in = 3'b000; ie = 1'b1; ex_valid = 1'b1; ex_pc = '0;
    ex_redirect = 1'b0; stall = 1'b0; uret_ex = 1'b0;
    step(2);
    rst = 1'b0;
    #1;
  endtask

  task automatic check_take(input string tag, input logic [31:0] tgt,
                            input logic [31:0] epc, input logic [1:0] cause);
    check({tag, "_take"}, int_take, 1);
    check({tag, "_target"}, int_target, tgt);
    check({tag, "_epc"}, epc_out, epc);
    check({tag, "_cause"}, cause_out, cause);
    check({tag, "_epc_we"}, epc_we, 1);
    check({tag, "_ie_clear"}, ie_clear, 1);
  endtask

  initial begin
    checks = 0;
    errors = 0;

    // Reset state
    do_reset();
    check("rst_take", int_take, 0);
    check("rst_target", int_target, 0);
    check("rst_epc", epc_out, 0);
    check("rst_cause", cause_out, 0);
    check("rst_pending", pending, 0);
    check("rst_in_service", in_service, 0);
    check("rst_state", state_dbg, S_IDLE);

    // Single request on source 1
    ex_pc = 32'h40;
    irq_in = 3'b010;
    step(2);
    check("single_pend_early", pending, 3'b000);
    step(1);
    check("single_pend", pending, 3'b010);
    check("single_no_take", int_take, 0);
    step(1);
    check("single_state_arm", state_dbg, S_ARM);
    check_take("single", 32'h1010, 32'h40, 2'd1);
    step(1);
    check("single_take_end", int_take, 0);
    check("single_in_service", in_service, 3'b010);
    check("single_pend_clr", pending, 3'b000);
    uret_ex = 1'b1;
    step(1);
    uret_ex = 1'b0;
    #1;
    check("single_uret", in_service, 3'b000);

    // Safe-slot wait on source 0
    do_reset();
    ex_pc = 32'h80;
    stall = 1'b1;
    irq_in = 3'b001;
    step(3);
    check("slot_pend", pending, 3'b001);
    step(1);
    check("slot_state_arm", state_dbg, S_ARM);
    check("slot_stall0", int_take, 0);
    step(1);
    check("slot_stall1", int_take, 0);
    step(1);
    check("slot_stall2", int_take, 0);
    stall = 1'b0; ex_redirect = 1'b1;
    #1;
    check("slot_redirect", int_take, 0);
    step(1);
    ex_redirect = 1'b0;
    #1;
    check_take("slot", 32'h1000, 32'h80, 2'd0);
    step(1);
    check("slot_in_service", in_service, 3'b001);

    // Priority and nesting
    do_reset();
    ex_pc = 32'h100;
    irq_in = 3'b101;
    step(3);
    check("prio_pend", pending, 3'b101);
    step(1);
    check_take("prio_src2", 32'h1020, 32'h100, 2'd2);
    step(1);
    check("prio_is2", in_service, 3'b100);
    check("prio_pend_left", pending, 3'b001);
    irq_in = 3'b111;
    step(3);
    check("prio_pend_src1", pending, 3'b011);
    check("prio_blocked_state", state_dbg, S_IDLE);
    step(1);
    check("prio_blocked_take", int_take, 0);
    uret_ex = 1'b1;
    #1;
    check("prio_uret_no_take", int_take, 0);
    step(1);
    uret_ex = 1'b0;
    #1;
    check("prio_uret_is", in_service, 3'b000);
    check("prio_after_uret_state", state_dbg, S_IDLE);
    step(1);
    check_take("prio_src1", 32'h1010, 32'h100, 2'd1);
    step(1);
    check("prio_is1", in_service, 3'b010);
    check("prio_pend_src0", pending, 3'b001);
    step(3);
    check("prio_src0_wait", int_take, 0);
    check("prio_src0_still", pending, 3'b001);
    uret_ex = 1'b1;
    step(1);
    uret_ex = 1'b0;
    #1;
    check("prio_uret2_is", in_service, 3'b000);
    step(1);
    check_take("prio_src0", 32'h1000, 32'h100, 2'd0);

    // Simultaneous set and clear of pending[0]
    do_reset();
    ex_pc = 32'h200;
    irq_in = 3'b001;
    step(1);
    irq_in = 3'b000;
    step(1);
    irq_in = 3'b001;
    step(1);
    check("simul_pend", pending, 3'b001);
    step(1);
    check_take("simul", 32'h1000, 32'h200, 2'd0);
    step(1);
    check("simul_pend_kept", pending, 3'b001);
    check("simul_is", in_service, 3'b001);

    // ie gating, including ARM -> IDLE when ie drops
    do_reset();
    ex_pc = 32'h300;
    ie = 1'b0;
    irq_in = 3'b100;
    step(3);
    check("ie_pend", pending, 3'b100);
    step(2);
    check("ie_idle", state_dbg, S_IDLE);
    check("ie_no_take", int_take, 0);
    stall = 1'b1; ie = 1'b1;
    step(1);
    check("ie_arm", state_dbg, S_ARM);
    check("ie_arm_stalled", int_take, 0);
    ie = 1'b0;
    #1;
    check("ie_drop_take", int_take, 0);
    step(1);
    check("ie_drop_idle", state_dbg, S_IDLE);
    stall = 1'b0; ie = 1'b1;
    #1;
    check("ie_reen_idle", int_take, 0);
    step(1);
    check_take("ie", 32'h1020, 32'h300, 2'd2);

    // Asynchronous reset mid-ARM
    do_reset();
    stall = 1'b1;
    irq_in = 3'b001;
    step(4);
    check("arst_arm", state_dbg, S_ARM);
    check("arst_pend_before", pending, 3'b001);
    #2;
    rst = 1'b1; irq_in = 3'b000;
    #1;
    check("arst_pend", pending, 3'b000);
    check("arst_state", state_dbg, S_IDLE);
    check("arst_take", int_take, 0);
    step(1);
    rst = 1'b0; stall = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step(1);
      check("arst_quiet", int_take, 0);
    end
    check("arst_quiet_pend", pending, 3'b000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
